// File: rtl/swap_pkg.sv
// Shared constants for the swap sorter: state encodings and default block geometry.
package swap_pkg;

    localparam int DEFAULT_DW    = 8;
    localparam int DEFAULT_DEPTH = 8;

    localparam logic [1:0] ST_LOAD  = 2'd0;
    localparam logic [1:0] ST_SORT  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    typedef enum logic [1:0] {
        S_LOAD  = ST_LOAD,
        S_SORT  = ST_SORT,
        S_DRAIN = ST_DRAIN
    } state_e;

endpackage

// File: rtl/cmp_swap.sv
// Combinational compare-and-swap: orders one pair of unsigned words.
module cmp_swap
    import swap_pkg::*;
#(
    parameter int DW = DEFAULT_DW
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] lo,
    output logic [DW-1:0] hi,
    output logic          swapped
);

    // Strict compare keeps equal words in place.
    assign swapped = (a > b);
    assign lo      = swapped ? b : a;
    assign hi      = swapped ? a : b;

endmodule

// File: rtl/swap_sort_ctrl.sv
// Block bubble sorter: load DEPTH words, sort with one shared compare-swap per cycle, stream out.
// Optional SWAP_STATS_EN adds a saturating per-block swap counter on swap_count.
module swap_sort_ctrl
    import swap_pkg::*;
#(
    parameter int DW    = DEFAULT_DW,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          busy
`ifdef SWAP_STATS_EN
    ,
    output logic [15:0]   swap_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_PTR  = AW'(DEPTH - 1);
    localparam logic [AW-1:0] LAST_PASS = AW'(DEPTH - 2);
    localparam logic [AW-1:0] ONE       = AW'(1);

    state_e                    state_q, state_d;
    logic [AW-1:0]             wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]             rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]             idx_q, idx_d;
    logic [AW-1:0]             pass_q, pass_d;
    logic                      pass_swp_q, pass_swp_d;
    logic                      in_ready_q, in_ready_d;
    logic                      out_valid_q, out_valid_d;
    logic [DW-1:0]             out_data_q, out_data_d;
    logic [DEPTH-1:0][DW-1:0]  mem_q, mem_d;

    logic [AW-1:0] idx_p1;
    logic [AW-1:0] last_idx;
    logic [DW-1:0] cmp_lo, cmp_hi;
    logic          cmp_swapped;

    assign idx_p1   = idx_q + ONE;
    assign last_idx = LAST_PASS - pass_q;

    cmp_swap #(.DW(DW)) u_cmp (
        .a       (mem_q[idx_q]),
        .b       (mem_q[idx_p1]),
        .lo      (cmp_lo),
        .hi      (cmp_hi),
        .swapped (cmp_swapped)
    );

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        idx_d       = idx_q;
        pass_d      = pass_q;
        pass_swp_d  = pass_swp_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        mem_d       = mem_q;
        out_data_d  = '0;
        case (state_q)
            S_LOAD: begin
                in_ready_d = 1'b1;
                if (in_valid && in_ready_q) begin
                    mem_d[wr_ptr_q] = in_data;
                    if (wr_ptr_q == LAST_PTR) begin
                        wr_ptr_d   = '0;
                        idx_d      = '0;
                        pass_d     = '0;
                        pass_swp_d = 1'b0;
                        in_ready_d = 1'b0;
                        state_d    = S_SORT;
                    end else begin
                        wr_ptr_d = wr_ptr_q + ONE;
                    end
                end
            end
            S_SORT: begin
                mem_d[idx_q]  = cmp_lo;
                mem_d[idx_p1] = cmp_hi;
                if (idx_q == last_idx) begin
                    // Leave after the final pass or after a pass that found nothing to swap.
                    if (pass_q == LAST_PASS || !(pass_swp_q || cmp_swapped)) begin
                        rd_ptr_d    = '0;
                        out_valid_d = 1'b1;
                        state_d     = S_DRAIN;
                    end else begin
                        pass_d     = pass_q + ONE;
                        idx_d      = '0;
                        pass_swp_d = 1'b0;
                    end
                end else begin
                    idx_d      = idx_p1;
                    pass_swp_d = pass_swp_q || cmp_swapped;
                end
            end
            S_DRAIN: begin
                if (out_valid_q && out_ready) begin
                    if (rd_ptr_q == LAST_PTR) begin
                        rd_ptr_d    = '0;
                        out_valid_d = 1'b0;
                        in_ready_d  = 1'b1;
                        state_d     = S_LOAD;
                    end else begin
                        rd_ptr_d = rd_ptr_q + ONE;
                    end
                end
            end
            default: begin
                in_ready_d  = 1'b0;
                out_valid_d = 1'b0;
                state_d     = S_LOAD;
            end
        endcase
        // Registered read port sees the post-swap buffer on the SORT->DRAIN edge.
        if (state_d == S_DRAIN) out_data_d = mem_d[rd_ptr_d];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_LOAD;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            idx_q       <= '0;
            pass_q      <= '0;
            pass_swp_q  <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            idx_q       <= idx_d;
            pass_q      <= pass_d;
            pass_swp_q  <= pass_swp_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_valid_q && (rd_ptr_q == LAST_PTR);
    assign busy      = (state_q != S_LOAD);

`ifdef SWAP_STATS_EN
    logic [15:0] swap_cnt_q, swap_cnt_d;

    always_comb begin
        swap_cnt_d = swap_cnt_q;
        if (state_q == S_LOAD && state_d == S_SORT)
            swap_cnt_d = '0;
        else if (state_q == S_SORT && cmp_swapped && swap_cnt_q != 16'hFFFF)
            swap_cnt_d = swap_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) swap_cnt_q <= '0;
        else       swap_cnt_q <= swap_cnt_d;
    end

    assign swap_count = swap_cnt_q;
`endif

endmodule
